id_stage: RTL and testbench
===========================

# id_stage

Instruction decode stage for the single-issue RV32I integer core. It sits directly upstream of the execute-stage ALU. It accepts one fetched instruction per cycle over a valid/ready handshake and reads source operands from an internal 32x32 register file. It registers the ALU control and operand payload (op_type, rs1 data, operand2, funct3, shamt) plus destination info for the execute stage. Only R-type (0110011) and I-type ALU (0010011) opcodes are legal; everything else is flagged illegal.

## Interface
- No parameters. XLEN is fixed at 32.
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- instr_valid_i  in  1  fetch presents an instruction.
- instr_i  in  32  instruction word.
- instr_ready_o  out  1  stage accepts instr_i this cycle.
- flush_i  in  1  discard the held payload and any instruction accepted this cycle.
- wb_en_i  in  1  writeback write enable.
- wb_addr_i  in  5  writeback register index.
- wb_data_i  in  32  writeback data.
- ex_valid_o  out  1  payload valid toward execute.
- ex_ready_i  in  1  execute consumes the payload.
- op_type_o  out  1  ALU sub/arith-shift select.
- rs1_data_o  out  32  source 1 value.
- operand2_o  out  32  rs2 value or sign-extended immediate.
- funct3_o  out  3  ALU function.
- shamt_o  out  5  shift amount.
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  destination write enable.
- illegal_o  out  1  instruction not supported.

## Operation
- **Acceptance.** `accept = instr_valid_i & instr_ready_o & !rst_i`.
- **Ready.** `instr_ready_o = !ex_valid_o | ex_ready_i | flush_i`. This is purely combinational.
- **Decode fields.** opcode = instr[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25].
- **R-type (0110011).**
  - operand2 = RF[rs2]; shamt = RF[rs2][4:0]; op_type = instr[30].
  - Legal if funct7 = 0000000, or funct7 = 0100000 with funct3 ∈ {000, 101}.
- **I-type (0010011).**
  - operand2 = sign-extended instr[31:20]; shamt = instr[24:20].
  - op_type = instr[30] only when funct3 = 101; otherwise 0. ADDI/XORI etc. with imm[10] set must never select subtract.
  - funct3 001 is legal only with funct7 = 0000000.
  - funct3 101 is legal only with funct7 ∈ {0000000, 0100000}.
- **Illegal instructions.** Any other opcode, or an illegal funct7 combination, is still delivered with illegal_o=1, rd_we_o=0 and all other fields decoded as above.
- **Destination enable.** rd_we_o = legal & (rd != 0).
- **Register file.**
  - x0 reads as 0; writes to x0 are ignored.
  - The write occurs on the clock edge when wb_en_i is high.
  - Read bypass: if wb_en_i and wb_addr_i == read index != 0, the read returns wb_data_i in the same cycle.
  - All 31 registers reset asynchronously to 0.
- **Operand sampling.** Operands are sampled at acceptance only. Writebacks occurring while a payload is held do not update it. RAW resolution beyond the same-cycle bypass belongs to execute-stage forwarding.
- **Output register updates.**
  - On accept & !flush_i: load the payload and set ex_valid_o=1.
  - Else if ex_ready_i | flush_i: clear ex_valid_o.
  - Otherwise hold every output stable.
- **Flush.** flush_i wins over a simultaneous accept: the instruction is consumed and dropped, and ex_valid_o=0 next cycle.

## Timing
- **Reset values.** ex_valid_o=0, op_type_o=0, rs1_data_o=0, operand2_o=0, funct3_o=0, shamt_o=0, rd_addr_o=0, rd_we_o=0, illegal_o=0. instr_ready_o reads 1 but accepts nothing while rst_i is high.
- **Latency.** 1 cycle: an instruction accepted at edge N appears on the outputs after edge N with ex_valid_o=1.
- **Throughput.** 1 instruction/cycle when ex_ready_i is held high.
- **Back-pressure.** While ex_valid_o & !ex_ready_i & !flush_i: instr_ready_o=0 and payload bits are unchanged.
- **Reset mid-operation.** Asserting rst_i drops any held payload immediately (asynchronously).

## Structure
- **Shared package rv_pkg:**
  - OPC_RTYPE = 7'b0110011, OPC_ITYPE = 7'b0010011.
  - F7_BASE = 7'b0000000, F7_ALT = 7'b0100000.
  - A funct3 enum: ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND.
  - The execute ALU uses the same constants.
- **Sub-module rv_regfile:** 2 read, 1 write, with write-to-read bypass and x0 hardwiring. It is instantiated once in id_stage.

## Test plan
- **Reset.** Assert rst_i mid-stream -> ex_valid_o=0 and all payload outputs 0 immediately; no accept until deassert.
- **ADDI and I-type op_type masking.**
  - 0xFFB00093 (addi x1,x0,-5) -> next cycle: operand2_o=0xFFFFFFFB, funct3_o=0, op_type_o=0, rd_addr_o=1, rd_we_o=1.
  - 0x40000093 (addi x1,x0,1024) -> operand2_o=0x400, op_type_o=0.
- **Same-cycle bypass on R-type SUB.** wb x2=0x12345678 and x1=5 written earlier; 0x401101B3 (sub x3,x2,x1) accepted in the same cycle as the x2 writeback -> rs1_data_o=0x12345678, operand2_o=5, op_type_o=1, rd_addr_o=3.
- **SRAI.** 0x40315213 (srai x4,x2,3) -> op_type_o=1, funct3_o=5, shamt_o=3.
  - Same field with funct7=0100001 -> illegal_o=1, rd_we_o=0.
- **Back-pressure then flush.** Hold ex_ready_i=0 for 3 cycles -> instr_ready_o=0, outputs bit-stable; release -> next instruction loads.
  - flush_i coincident with accept -> ex_valid_o=0 next cycle.
- **Illegal and x0 handling.** 0x00000073 (ecall) -> illegal_o=1, rd_we_o=0.
  - wb to x0 with 0xFFFFFFFF, then read x0 -> rs1_data_o=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, used by both the decode and execute stages.
package rv_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ADD_SUB = 3'b000,
        SLL     = 3'b001,
        SLT     = 3'b010,
        SLTU    = 3'b011,
        XOR     = 3'b100,
        SRL_SRA = 3'b101,
        OR      = 3'b110,
        AND     = 3'b111
    } funct3_e;

    // Sign-extend the 12-bit I-type immediate held in instr[31:20].
    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two read ports, one write port,
// same-cycle write-to-read bypass, x0 hardwired to zero.
module rv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    // Register storage; x0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports with bypass of a writeback landing on this same edge.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (we && (waddr == rs1_addr)) begin
            rs1_data = wdata;
        end

        rs2_data = regs[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (we && (waddr == rs2_addr)) begin
            rs2_data = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: accepts one instruction per cycle, reads operands from the
// register file and registers the ALU payload for the execute stage.
module id_stage
    import rv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    input  logic        flush_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic        op_type_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] operand2_o,
    output logic [2:0]  funct3_o,
    output logic [4:0]  shamt_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    funct3_e     f3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        legal;
    logic        op_type;
    logic [31:0] operand2;
    logic [4:0]  shamt;
    logic        accept;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign f3     = funct3_e'(funct3);

    assign instr_ready_o = !ex_valid_o || ex_ready_i || flush_i;
    assign accept        = instr_valid_i && instr_ready_o && !rst_i;

    rv_regfile u_regfile (
        .clk      (clk_i),
        .rst      (rst_i),
        .rs1_addr (rs1),
        .rs1_data (rs1_data),
        .rs2_addr (rs2),
        .rs2_data (rs2_data),
        .we       (wb_en_i),
        .waddr    (wb_addr_i),
        .wdata    (wb_data_i)
    );

    // Field decode and legality; non-ALU opcodes fall through with the I-type operand view.
    always_comb begin
        legal    = 1'b0;
        op_type  = 1'b0;
        operand2 = imm_i(instr_i);
        shamt    = instr_i[24:20];
        if (opcode == OPC_RTYPE) begin
            operand2 = rs2_data;
            shamt    = rs2_data[4:0];
            op_type  = instr_i[30];
            legal    = (funct7 == F7_BASE) ||
                       ((funct7 == F7_ALT) && ((f3 == ADD_SUB) || (f3 == SRL_SRA)));
        end else if (opcode == OPC_ITYPE) begin
            legal = 1'b1;
            case (f3)
                SLL:     legal = (funct7 == F7_BASE);
                SRL_SRA: begin
                    legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    // Only shifts use instr[30]; immediates with bit 10 set must not subtract.
                    op_type = instr_i[30];
                end
                default: ;
            endcase
        end
    end

    // Payload register: load on accept, drop on consume or flush, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_o <= 1'b0;
            op_type_o  <= 1'b0;
            rs1_data_o <= '0;
            operand2_o <= '0;
            funct3_o   <= '0;
            shamt_o    <= '0;
            rd_addr_o  <= '0;
            rd_we_o    <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (accept && !flush_i) begin
            ex_valid_o <= 1'b1;
            op_type_o  <= op_type;
            rs1_data_o <= rs1_data;
            operand2_o <= operand2;
            funct3_o   <= funct3;
            shamt_o    <= shamt;
            rd_addr_o  <= rd;
            rd_we_o    <= legal && (rd != 5'd0);
            illegal_o  <= !legal;
        end else if (ex_ready_i || flush_i) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases plus random traffic against a reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic        op_type;
    logic [31:0] rs1_data;
    logic [31:0] operand2;
    logic [2:0]  funct3;
    logic [4:0]  shamt;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] mrf [32];
    logic        m_valid;
    logic        m_op;
    logic [31:0] m_rs1;
    logic [31:0] m_op2;
    logic [2:0]  m_f3;
    logic [4:0]  m_shamt;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        m_ill;
    logic        m_alu;   // payload came from an ALU opcode: all fields are checked

    always #5 clk = ~clk;

    id_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_ready_o (instr_ready),
        .flush_i       (flush),
        .wb_en_i       (wb_en),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .ex_valid_o    (ex_valid),
        .ex_ready_i    (ex_ready),
        .op_type_o     (op_type),
        .rs1_data_o    (rs1_data),
        .operand2_o    (operand2),
        .funct3_o      (funct3),
        .shamt_o       (shamt),
        .rd_addr_o     (rd_addr),
        .rd_we_o       (rd_we),
        .illegal_o     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        m_valid = 0; m_op = 0; m_rs1 = 0; m_op2 = 0; m_f3 = 0;
        m_shamt = 0; m_rd = 0; m_we = 0; m_ill = 0; m_alu = 1;
    endtask

    // Evaluate what the next rising edge must do, given the inputs now applied.
    task automatic model_step();
        logic        ready, acc, is_r, is_i, legal;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        if (rst) begin
            model_reset();
            return;
        end
        ready = !m_valid || ex_ready || flush;
        acc   = instr_valid && ready;
        if (acc && !flush) begin
            opc  = instr[6:0];
            f3   = instr[14:12];
            f7   = instr[31:25];
            is_r = (opc == 7'h33);
            is_i = (opc == 7'h13);
            a    = mread(instr[19:15]);
            b    = mread(instr[24:20]);
            if (is_r) legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            else if (is_i && f3 == 3'd1) legal = (f7 == 7'h00);
            else if (is_i && f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else legal = is_i;
            m_valid = 1;
            m_alu   = is_r || is_i;
            m_rs1   = a;
            m_f3    = f3;
            m_rd    = instr[11:7];
            m_ill   = !legal;
            m_we    = legal && (instr[11:7] != 0);
            if (is_r) begin
                m_op2   = b;
                m_shamt = b[4:0];
                m_op    = instr[30];
            end else begin
                m_op2   = 32'(signed'(instr[31:20]));
                m_shamt = instr[24:20];
                m_op    = (f3 == 3'd5) ? instr[30] : 1'b0;
            end
        end else if (ex_ready || flush) begin
            m_valid = 0;
        end
        if (wb_en && wb_addr != 0) mrf[wb_addr] = wb_data;
    endtask

    task automatic compare_outputs();
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        check("rs1_data", rs1_data, m_rs1);
        check("funct3", 32'(funct3), 32'(m_f3));
        check("rd_addr", 32'(rd_addr), 32'(m_rd));
        check("rd_we", 32'(rd_we), 32'(m_we));
        check("illegal", 32'(illegal), 32'(m_ill));
        if (m_alu) begin
            check("op_type", 32'(op_type), 32'(m_op));
            check("operand2", operand2, m_op2);
            check("shamt", 32'(shamt), 32'(m_shamt));
        end
    endtask

    // One clock: apply inputs at the falling edge, check ready, then outputs after the edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr_valid = v; instr = ins; ex_ready = rdy; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        check("instr_ready", 32'(instr_ready), 32'(!m_valid || rdy || fl));
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    logic [31:0] snap_op2, snap_rs1;

    initial begin
        rst = 1; instr_valid = 0; instr = 0; flush = 0; ex_ready = 1;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        model_reset();
        @(negedge clk);
        check("reset_ready", 32'(instr_ready), 32'd1);
        compare_outputs();
        // Valid instruction offered under reset must not be taken.
        cycle(1, 32'hFFB00093, 1, 0, 0, 0, 0);
        rst = 0;

        cycle(1, 32'hFFB00093, 1, 0, 0, 0, 0);
        check("addi_op2", operand2, 32'hFFFFFFFB);
        check("addi_we", 32'(rd_we), 32'd1);
        cycle(1, 32'h40000093, 1, 0, 0, 0, 0);
        check("addi_mask_op", 32'(op_type), 32'd0);
        check("addi_op2_400", operand2, 32'h400);
        cycle(0, 32'h0, 1, 0, 1, 5'd1, 32'd5);
        cycle(1, 32'h401101B3, 1, 0, 1, 5'd2, 32'h12345678);
        check("sub_bypass", rs1_data, 32'h12345678);
        check("sub_op_type", 32'(op_type), 32'd1);
        cycle(1, 32'h40315213, 1, 0, 0, 0, 0);
        check("srai_shamt", 32'(shamt), 32'd3);
        cycle(1, 32'h42315213, 1, 0, 0, 0, 0);
        check("srai_bad_f7", 32'(illegal), 32'd1);

        // Back-pressure: payload must stay bit-stable, even across a writeback.
        cycle(1, 32'h00708293, 1, 0, 0, 0, 0);
        snap_op2 = operand2; snap_rs1 = rs1_data;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h00210313, 0, 0, 1, 5'd1, 32'hDEAD0000);
            check("bp_hold_op2", operand2, snap_op2);
            check("bp_hold_rs1", rs1_data, snap_rs1);
        end
        cycle(1, 32'h00210313, 1, 0, 0, 0, 0);
        check("bp_release_rd", 32'(rd_addr), 32'd6);
        cycle(1, 32'h00110393, 1, 1, 0, 0, 0);
        check("flush_drop", 32'(ex_valid), 32'd0);

        cycle(1, 32'h00000073, 1, 0, 0, 0, 0);
        check("ecall_ill", 32'(illegal), 32'd1);
        cycle(0, 32'h0, 1, 0, 1, 5'd0, 32'hFFFFFFFF);
        cycle(1, 32'h00100313, 1, 0, 1, 5'd0, 32'hFFFFFFFF);
        check("x0_read", rs1_data, 32'd0);

        // Asynchronous reset while a payload is held.
        cycle(1, 32'h401101B3, 0, 0, 0, 0, 0);
        #2 rst = 1;
        model_reset();
        #1;
        compare_outputs();
        cycle(1, 32'h00100313, 1, 0, 0, 0, 0);
        rst = 0;

        for (int n = 0; n < 600; n++) begin
            logic [6:0]  opc, f7;
            logic [31:0] ins;
            int          r;
            r = $urandom_range(0, 9);
            opc = (r < 4) ? 7'h33 : (r < 8) ? 7'h13 : 7'($urandom);
            r = $urandom_range(0, 5);
            f7 = (r < 3) ? 7'h00 : (r < 5) ? 7'h20 : 7'($urandom);
            ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   3'($urandom), 5'($urandom_range(0, 7)), opc};
            cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
